sme_wild: RTL
=============

# sme_wild

Parametrised string-matching engine, successor to the fixed 32-char/8-char matcher in the contest tree. Serially loads a target string and one or more patterns. Each pattern is searched against the current string, with `^`, `$` and `.` anchors/wildcards plus a new `*` (zero-or-more any-character) element. Reports match/no-match and the leftmost match start index. Widths and depths are parameters.

## Interface
- `CHAR_W`, 8, character width in bits.
- `MAX_STR`, 32, string buffer depth in characters.
- `MAX_PAT`, 16, pattern buffer depth in characters.
- `IDX_W`, $clog2(MAX_STR)+1, width of `match_index`; derived, not overridden.

- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `chardata` input CHAR_W: character presented with `isstring` or `ispattern`.
- `isstring` input 1: `chardata` is the next string character.
- `ispattern` input 1: `chardata` is the next pattern character.
- `busy` output 1: search in progress; inputs are ignored while high.
- `valid` output 1: one-cycle pulse; result is available.
- `match` output 1: the pattern was found.
- `match_index` output IDX_W: start position of the leftmost match.

## Operation
- Element semantics, given string s[0..L-1] and cursor p:
  - Literal c: requires p<L and s[p]==c; advances the cursor 1.
  - `.` (0x2E): requires p<L; advances 1.
  - `^` (0x5E): zero-width; true if p==0 or s[p-1]==0x20.
  - `$` (0x24): zero-width; true if p==L or s[p]==0x20.
  - `*` (0x2A): only the first `*` in a pattern is special. Any later `*` is a literal 0x2A.
- The pattern splits at the first `*` into HEAD and TAIL. With no `*`, TAIL is absent.
- Search order:
  - Try HEAD at start st=0,1,…,L. The first st where HEAD matches fixes `match_index`=st and head end e.
  - Then try TAIL at q=e,…,L. The first success gives `match`=1.
  - If TAIL never matches, `match`=0 and the search does not retry a later st.
  - An empty HEAD matches at st=0. An empty TAIL always matches.
- On `match`=0, `match_index`=0.
- States:
  - LOAD → HEAD on the first cycle with `isstring`=`ispattern`=0 after at least one pattern char has been captured.
  - HEAD → TAIL when HEAD matches at some st and a `*` is present.
  - HEAD → DONE when HEAD succeeds with no `*`, or when st>L.
  - TAIL → DONE on success or when q>L.
  - DONE → LOAD unconditionally.
- Loading:
  - The first `isstring` cycle after a `valid` pulse, or after reset, starts a new string: L←1, s[0]←chardata.
  - Later `isstring` cycles append.
  - The pattern length resets to 0 at every `valid`. Each pattern is one transaction; the string persists across patterns.
- Overflow: characters beyond MAX_STR or MAX_PAT are dropped, and the length saturates.
- `isstring` and `ispattern` high together: treated as string only.
- A pattern with no prior string searches with L=0.

## Timing
- Reset values: `valid`=0, `match`=0, `match_index`=0, `busy`=0, state LOAD, both lengths 0.
- Capture latency: 1 cycle per character.
- HEAD and TAIL each evaluate one pattern element per cycle. On an element mismatch, the start or cursor advances by 1 and the element pointer resets, in the same cycle.
- Search length: worst case (L+1)·P + 2 cycles.
- `busy` is high from the LOAD→HEAD transition through DONE.
- `valid` rises the cycle after DONE is entered and lasts exactly 1 cycle. `match` and `match_index` hold until the next `valid`.
- `reset` asserted in any state, including mid-search: next cycle is LOAD with the reset values, and no `valid` is issued for the aborted pattern.

## Test plan
- String "hello world", pattern "wor" → `valid` pulse, `match`=1, `match_index`=6.
- Same string, then patterns "^wo", "o$", "l.o" → results (1,6), (1,4), (1,2), each with its own `valid` pulse.
- Same string, patterns "h*d", "*rld$", "w*h" → (1,0), (1,0), (0,0); "^*d$" → (1,0).
- New string "abc" after a `valid` replaces the old string; pattern "c$" → (1,2). A 40-char string → only 32 chars are kept, and pattern "$" → (1,32).
- `isstring` and `ispattern` pulsed while `busy` → ignored, and the result is unchanged.
- `reset` asserted mid-HEAD → no `valid`. Reloading "abc"/"b" then gives (1,1).

Source files
------------

// File: rtl/sme_wild.sv
// sme_wild -- parametrised string-matching engine with anchors and a single
// zero-or-more wildcard.
//
// A target string and a pattern are loaded one character per cycle. The
// engine then searches the pattern against the string and reports whether it
// was found. It also reports the leftmost start index of the match.
//
// Pattern elements:
//   literal  matches one equal character
//   '.'      matches any one character
//   '^'      zero-width: start of string or just after a space
//   '$'      zero-width: end of string or just before a space
//   '*'      the first one splits the pattern into HEAD and TAIL and
//            stands for zero or more characters; later '*' are literals
//
// HEAD is tried at start positions 0..L. The first hit fixes match_index.
// TAIL is then tried at cursor positions from the end of HEAD up to L. A TAIL
// failure ends the search; the engine does not retry a later HEAD start.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   chardata     character presented with isstring / ispattern
//   isstring     chardata is the next string character (wins over ispattern)
//   ispattern    chardata is the next pattern character
//   busy         search in progress; inputs ignored while high
//   valid        one-cycle result strobe
//   match        pattern found (held until the next valid)
//   match_index  start of leftmost match, 0 when no match (held)

module sme_wild #(
  parameter  int CHAR_W  = 8,
  parameter  int MAX_STR = 32,
  parameter  int MAX_PAT = 16,
  localparam int IDX_W   = $clog2(MAX_STR) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              busy,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index
);

  // Address widths for the two buffers. The length registers carry one
  // extra bit so they can hold the full buffer depth.
  localparam int SAW = $clog2(MAX_STR);
  localparam int PAW = $clog2(MAX_PAT);
  localparam int PW  = PAW + 1;

  localparam logic [IDX_W-1:0]  STR_MAX_V = IDX_W'(MAX_STR);
  localparam logic [PW-1:0]     PAT_MAX_V = PW'(MAX_PAT);

  localparam logic [CHAR_W-1:0] CH_DOT    = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] CH_CARET  = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] CH_DOLLAR = CHAR_W'(8'h24);
  localparam logic [CHAR_W-1:0] CH_STAR   = CHAR_W'(8'h2A);
  localparam logic [CHAR_W-1:0] CH_SPACE  = CHAR_W'(8'h20);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_HEAD,
    ST_TAIL,
    ST_DONE
  } state_t;

  state_t state;

  logic [CHAR_W-1:0] str_buf [MAX_STR];
  logic [CHAR_W-1:0] pat_buf [MAX_PAT];
  logic [IDX_W-1:0]  str_len;
  logic [PW-1:0]     pat_len;
  logic              new_str;
  logic              has_star;
  logic [PW-1:0]     star_pos;

  // base is the HEAD start (st) while in HEAD, and the TAIL start (q) while
  // in TAIL. cur is the string cursor and ep is the pattern element pointer.
  logic [IDX_W-1:0]  base;
  logic [IDX_W-1:0]  cur;
  logic [PW-1:0]     ep;
  logic              res_match;
  logic [IDX_W-1:0]  res_index;

  logic [PW-1:0]     seg_end;
  logic              at_end;
  logic [CHAR_W-1:0] elem;
  logic              in_str;
  logic [CHAR_W-1:0] ch_cur;
  logic [CHAR_W-1:0] ch_prev;
  logic [IDX_W-1:0]  cur_m1;
  logic              elem_ok;
  logic              elem_adv;
  logic [IDX_W-1:0]  cur_next;

  // Evaluate the single pattern element under ep against the cursor.
  // HEAD ends at the first star (or at the pattern end when there is no
  // star). TAIL always ends at the pattern end. Reads of the string are
  // guarded so that the cursor may sit one past the last character.
  always_comb begin
    seg_end  = (state == ST_TAIL || !has_star) ? pat_len : star_pos;
    at_end   = (ep >= seg_end);
    elem     = (ep < PAT_MAX_V) ? pat_buf[ep[PAW-1:0]] : '0;
    in_str   = (cur < str_len);
    ch_cur   = in_str ? str_buf[cur[SAW-1:0]] : '0;
    cur_m1   = cur - IDX_W'(1);
    ch_prev  = (cur != '0) ? str_buf[cur_m1[SAW-1:0]] : '0;
    elem_ok  = 1'b0;
    elem_adv = 1'b0;
    if (elem == CH_DOT) begin
      elem_ok  = in_str;
      elem_adv = in_str;
    end else if (elem == CH_CARET) begin
      elem_ok  = (cur == '0) || (ch_prev == CH_SPACE);
    end else if (elem == CH_DOLLAR) begin
      elem_ok  = !in_str || (ch_cur == CH_SPACE);
    end else begin
      // Anything else, including a '*' after the first one, is a literal.
      elem_ok  = in_str && (ch_cur == elem);
      elem_adv = elem_ok;
    end
    cur_next = cur + IDX_W'(elem_adv);
  end

  // Main controller: loading, the two search phases, and result delivery.
  // The result registers are copied to the outputs in DONE so that match
  // and match_index change together with the valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      busy        <= 1'b0;
      str_len     <= '0;
      pat_len     <= '0;
      new_str     <= 1'b1;
      has_star    <= 1'b0;
      star_pos    <= '0;
      base        <= '0;
      cur         <= '0;
      ep          <= '0;
      res_match   <= 1'b0;
      res_index   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (isstring) begin
            // The first string character after a result replaces the
            // whole string. Later characters append until the buffer is full.
            if (new_str) begin
              str_buf[0] <= chardata;
              str_len    <= IDX_W'(1);
              new_str    <= 1'b0;
            end else if (str_len < STR_MAX_V) begin
              str_buf[str_len[SAW-1:0]] <= chardata;
              str_len                   <= str_len + IDX_W'(1);
            end
          end else if (ispattern) begin
            if (pat_len < PAT_MAX_V) begin
              pat_buf[pat_len[PAW-1:0]] <= chardata;
              pat_len                   <= pat_len + PW'(1);
              if (chardata == CH_STAR && !has_star) begin
                has_star <= 1'b1;
                star_pos <= pat_len;
              end
            end
          end else if (pat_len != '0) begin
            state     <= ST_HEAD;
            busy      <= 1'b1;
            base      <= '0;
            cur       <= '0;
            ep        <= '0;
            res_match <= 1'b0;
            res_index <= '0;
          end
        end

        ST_HEAD: begin
          if (at_end) begin
            res_index <= base;
            if (has_star) begin
              state <= ST_TAIL;
              base  <= cur;
              ep    <= star_pos + PW'(1);
            end else begin
              res_match <= 1'b1;
              state     <= ST_DONE;
            end
          end else if (elem_ok) begin
            cur <= cur_next;
            ep  <= ep + PW'(1);
          end else if (base >= str_len) begin
            res_match <= 1'b0;
            res_index <= '0;
            state     <= ST_DONE;
          end else begin
            base <= base + IDX_W'(1);
            cur  <= base + IDX_W'(1);
            ep   <= '0;
          end
        end

        ST_TAIL: begin
          // res_index already holds the HEAD start. A TAIL failure at the
          // last position clears it, since a no-match reports index 0.
          if (at_end) begin
            res_match <= 1'b1;
            state     <= ST_DONE;
          end else if (elem_ok) begin
            cur <= cur_next;
            ep  <= ep + PW'(1);
          end else if (base >= str_len) begin
            res_match <= 1'b0;
            res_index <= '0;
            state     <= ST_DONE;
          end else begin
            base <= base + IDX_W'(1);
            cur  <= base + IDX_W'(1);
            ep   <= star_pos + PW'(1);
          end
        end

        ST_DONE: begin
          valid       <= 1'b1;
          busy        <= 1'b0;
          match       <= res_match;
          match_index <= res_index;
          pat_len     <= '0;
          has_star    <= 1'b0;
          star_pos    <= '0;
          new_str     <= 1'b1;
          state       <= ST_LOAD;
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
